johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 5-bit Johnson (twisted-ring) counter. It samples the counter's 5-bit code every clock and decodes it into a one-hot 10-phase bus and a binary phase index. It checks that each code is a legal Johnson state and is the legal successor of the previous one. It tracks lock, flags sequence errors, and counts full revolutions for the timing logic further downstream.

## Interface
- `REV_W`, default 8: width of the revolution counter.
- `LOCK_CNT`, default 3: number of consecutive correct successor steps required to declare lock (range 1..15).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `code_in`  in  5  Johnson code from the counter; bit 4 is the stage fed by the inverted bit 0.
- `resync`  in  1  high in the cycle the upstream counter was reloaded; suppresses the successor check for that sample.
- `clr_err`  in  1  synchronous clear of `err_sticky`.
- `phase`  out  10  one-hot decoded phase; all zero when the code is illegal.
- `phase_idx`  out  4  binary phase 0..9; 4'hF when the code is illegal.
- `valid`  out  1  registered code was legal.
- `locked`  out  1  FSM in LOCKED.
- `err`  out  1  one-cycle pulse on a sequence fault while locked.
- `err_sticky`  out  1  latched fault flag.
- `rev_count`  out  REV_W  completed revolutions while locked, modulo 2^REV_W.
- `rev_tick`  out  1  one-cycle pulse on each 9→0 step while locked.

## Operation
- Legal code-to-index map:
  - 00000 = 0, 10000 = 1, 11000 = 2, 11100 = 3, 11110 = 4
  - 11111 = 5, 01111 = 6, 00111 = 7, 00011 = 8, 00001 = 9
  - The other 22 codes are illegal.
- Decode stage, every clock: `valid` <= legal; `phase_idx` <= idx or 4'hF; `phase` <= onehot(idx) or 0.
- `succ_ok` = registered `valid` & legal & (idx == (registered `phase_idx` + 1) mod 10). The step 9→0 counts as a successor. A repeated code is not a successor.
- The FSM has two states, UNLOCKED and LOCKED, plus a 4-bit good counter `gcnt`.
- UNLOCKED:
  - resync or illegal code: `gcnt` <= 0.
  - `succ_ok`: `gcnt` + 1; on reaching LOCK_CNT → LOCKED, `gcnt` <= 0.
  - Legal non-successor: `gcnt` <= 0.
  - No `err` is raised in UNLOCKED.
- LOCKED:
  - resync: → UNLOCKED, `gcnt` <= 0, no error.
  - Else `!succ_ok` (illegal, skipped or repeated code): `err` <= 1 for one cycle, `err_sticky` <= 1, → UNLOCKED.
- Revolution counting: when in LOCKED and `succ_ok` with idx == 0 and no resync, `rev_tick` <= 1 and `rev_count` increments. `rev_count` wraps silently from 2^REV_W−1 to 0. It is not cleared on loss of lock; only reset clears it.
- `err_sticky`: set has priority over `clr_err` in the same cycle. Otherwise `clr_err` clears it.
- Priority order: reset > resync > fault detection > counting.

## Timing
- Latency: a code sampled at edge N appears on `phase`, `phase_idx`, `valid`, `err`, `rev_tick` and `locked` after edge N. All of these are registered; none is combinational from inputs.
- `err` and `rev_tick` are single-cycle pulses and are never high together.
- Lock timing, with LOCK_CNT = 3 and legal codes 0,1,2,3 sampled at edges 1..4 after reset: `locked` = 1 after edge 4.
- Fault exit timing: a bad sample at edge N gives `err` = 1 and `locked` = 0 after edge N. Relock needs LOCK_CNT further successors.
- Reset values: `phase` = 0, `phase_idx` = 4'hF, `valid` = 0, `locked` = 0, `err` = 0, `err_sticky` = 0, `rev_count` = 0, `rev_tick` = 0, FSM = UNLOCKED, `gcnt` = 0.
- Reset asserted mid-run: all of the above hold on the next edge. The first sample after reset deasserts never counts as a successor.

## Test plan
- Free run: reset, then the counter from 00000 for 25 cycles. Expect `locked` = 1 after the 4th sample and `phase` walking 0x001→0x002→…→0x200→0x001. Expect `rev_tick` at each 9→0 step, giving `rev_count` = 2. Expect `err` = 0 throughout.
- Illegal code while locked: force `code_in` = 10100 for one cycle. Expect `valid` = 0, `phase_idx` = 4'hF, `phase` = 0, `err` pulse, `err_sticky` = 1, `locked` = 0. Expect relock after 3 successors once the legal sequence resumes.
- Skip fault: while locked, drive phase 3 then 11111 (phase 5). Expect `err` = 1, `valid` = 1, `phase_idx` = 5, `locked` = 0.
- Resync: while locked at phase 6, upstream reloads 10000 with `resync` = 1. Expect `locked` = 0, `err` = 0, `err_sticky` unchanged. Expect relock 3 samples later (phase 4).
- Sticky clear: `clr_err` = 1 in the same cycle as a new fault gives `err_sticky` = 1. A later `clr_err` alone gives `err_sticky` = 0.
- Wrap: with REV_W = 2, run 5 locked revolutions. Expect `rev_count` sequence 1,2,3,0,1. Assert reset mid-revolution and expect all outputs at their reset values next cycle.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//    Samples a 5-bit Johnson (twisted-ring) counter code every clock.
//    It decodes the code into a one-hot 10-phase bus and a binary index.
//    It also checks that each code is legal and is the successor of the
//    previous code. From that it tracks lock, flags sequence faults, and
//    counts full revolutions.
//
// Ports
//    clk         in   system clock, rising edge
//    reset       in   synchronous active-high reset
//    code_in     in   [4:0] Johnson code, bit 4 is fed by the inverted bit 0
//    resync      in   upstream counter was reloaded this cycle
//    clr_err     in   synchronous clear of err_sticky
//    phase       out  [9:0] one-hot phase, zero when the code is illegal
//    phase_idx   out  [3:0] binary phase 0..9, 4'hF when the code is illegal
//    valid       out  registered code was legal
//    locked      out  FSM is in LOCKED
//    err         out  one-cycle pulse on a sequence fault while locked
//    err_sticky  out  latched fault flag
//    rev_count   out  [REV_W-1:0] completed revolutions while locked
//    rev_tick    out  one-cycle pulse on each locked 9->0 step

module johnson_phase_decoder #(
   parameter int REV_W    = 8,
   parameter int LOCK_CNT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       code_in,
   input  logic             resync,
   input  logic             clr_err,
   output logic [9:0]       phase,
   output logic [3:0]       phase_idx,
   output logic             valid,
   output logic             locked,
   output logic             err,
   output logic             err_sticky,
   output logic [REV_W-1:0] rev_count,
   output logic             rev_tick
);

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;
   localparam logic [3:0] LOCK_TGT    = 4'(LOCK_CNT);

   logic [9:0]       phase_q,      phase_d;
   logic [3:0]       phase_idx_q,  phase_idx_d;
   logic             valid_q,      valid_d;
   logic [0:0]       state_q,      state_d;
   logic [3:0]       gcnt_q,       gcnt_d;
   logic             err_q,        err_d;
   logic             err_sticky_q, err_sticky_d;
   logic [REV_W-1:0] rev_count_q,  rev_count_d;
   logic             rev_tick_q,   rev_tick_d;

   logic       legal;
   logic [3:0] idx;
   logic [3:0] next_idx;
   logic       succ_ok;

   // Decode the code into an index. Any code that is not one of the ten
   // Johnson states is illegal.
   always_comb begin
      legal = 1'b1;
      idx   = 4'hF;
      case (code_in)
         5'b00000: idx = 4'd0;
         5'b10000: idx = 4'd1;
         5'b11000: idx = 4'd2;
         5'b11100: idx = 4'd3;
         5'b11110: idx = 4'd4;
         5'b11111: idx = 4'd5;
         5'b01111: idx = 4'd6;
         5'b00111: idx = 4'd7;
         5'b00011: idx = 4'd8;
         5'b00001: idx = 4'd9;
         default:  legal = 1'b0;
      endcase
   end

   // A successor needs a legal previous sample. After reset or after an
   // illegal code, valid_q is low, so the next sample can never count as
   // a step, whatever phase_idx_q holds.
   always_comb begin
      next_idx = (phase_idx_q == 4'd9) ? 4'd0 : phase_idx_q + 4'd1;
      succ_ok  = valid_q & legal & (idx == next_idx);
   end

   always_comb begin
      valid_d     = legal;
      phase_idx_d = idx;
      phase_d     = legal ? (10'd1 << idx) : 10'd0;
   end

   always_comb begin
      state_d      = state_q;
      gcnt_d       = gcnt_q;
      err_d        = 1'b0;
      rev_tick_d   = 1'b0;
      rev_count_d  = rev_count_q;
      err_sticky_d = err_sticky_q;
      case (state_q)
         ST_UNLOCKED: begin
            if (resync || !legal) begin
               gcnt_d = 4'd0;
            end else if (succ_ok) begin
               if (gcnt_q + 4'd1 == LOCK_TGT) begin
                  state_d = ST_LOCKED;
                  gcnt_d  = 4'd0;
               end else begin
                  gcnt_d = gcnt_q + 4'd1;
               end
            end else begin
               gcnt_d = 4'd0;
            end
         end
         ST_LOCKED: begin
            gcnt_d = 4'd0;
            // A reload is an expected discontinuity, so it drops lock
            // without raising a fault.
            if (resync) begin
               state_d = ST_UNLOCKED;
            end else if (!succ_ok) begin
               err_d   = 1'b1;
               state_d = ST_UNLOCKED;
            end else if (idx == 4'd0) begin
               rev_tick_d  = 1'b1;
               rev_count_d = rev_count_q + REV_W'(1);
            end
         end
         default: begin
            state_d = ST_UNLOCKED;
            gcnt_d  = 4'd0;
         end
      endcase
      // A new fault wins over a clear in the same cycle.
      if (err_d) begin
         err_sticky_d = 1'b1;
      end else if (clr_err) begin
         err_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q      <= 10'd0;
         phase_idx_q  <= 4'hF;
         valid_q      <= 1'b0;
         state_q      <= ST_UNLOCKED;
         gcnt_q       <= 4'd0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         rev_count_q  <= '0;
         rev_tick_q   <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         phase_idx_q  <= phase_idx_d;
         valid_q      <= valid_d;
         state_q      <= state_d;
         gcnt_q       <= gcnt_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
         rev_count_q  <= rev_count_d;
         rev_tick_q   <= rev_tick_d;
      end
   end

   assign phase      = phase_q;
   assign phase_idx  = phase_idx_q;
   assign valid      = valid_q;
   assign locked     = (state_q == ST_LOCKED);
   assign err        = err_q;
   assign err_sticky = err_sticky_q;
   assign rev_count  = rev_count_q;
   assign rev_tick   = rev_tick_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder.
// Two instances share the same stimulus: dut_a uses the default REV_W,
// and dut_b uses REV_W = 2 so that the revolution counter wrap is visible.

module tb_johnson_phase_decoder;

   logic       clk;
   logic       reset;
   logic [4:0] code_in;
   logic       resync;
   logic       clr_err;

   logic [9:0] phase_a,   phase_b;
   logic [3:0] idx_a,     idx_b;
   logic       valid_a,   valid_b;
   logic       locked_a,  locked_b;
   logic       err_a,     err_b;
   logic       sticky_a,  sticky_b;
   logic [7:0] rev_a;
   logic [1:0] rev_b;
   logic       tick_a,    tick_b;

   int checks = 0;
   int errors = 0;

   johnson_phase_decoder dut_a (
      .clk(clk), .reset(reset), .code_in(code_in), .resync(resync),
      .clr_err(clr_err), .phase(phase_a), .phase_idx(idx_a), .valid(valid_a),
      .locked(locked_a), .err(err_a), .err_sticky(sticky_a),
      .rev_count(rev_a), .rev_tick(tick_a)
   );

   johnson_phase_decoder #(.REV_W(2)) dut_b (
      .clk(clk), .reset(reset), .code_in(code_in), .resync(resync),
      .clr_err(clr_err), .phase(phase_b), .phase_idx(idx_b), .valid(valid_b),
      .locked(locked_b), .err(err_b), .err_sticky(sticky_b),
      .rev_count(rev_b), .rev_tick(tick_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] jc(input int i);
      case (i)
         0: return 5'b00000;
         1: return 5'b10000;
         2: return 5'b11000;
         3: return 5'b11100;
         4: return 5'b11110;
         5: return 5'b11111;
         6: return 5'b01111;
         7: return 5'b00111;
         8: return 5'b00011;
         default: return 5'b00001;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares every output of one instance (sel 0 = dut_a, 1 = dut_b).
   task automatic expect_all(input string tag, input bit sel, input int pidx, input bit v,
                             input bit lk, input bit e, input bit st, input bit tk,
                             input int rc);
      logic [9:0] ph;
      ph = (pidx == 15) ? 10'd0 : (10'd1 << pidx);
      if (!sel) begin
         chk($sformatf("%s.phase", tag),  32'(phase_a),  32'(ph));
         chk($sformatf("%s.idx", tag),    32'(idx_a),    32'(pidx));
         chk($sformatf("%s.valid", tag),  32'(valid_a),  32'(v));
         chk($sformatf("%s.locked", tag), 32'(locked_a), 32'(lk));
         chk($sformatf("%s.err", tag),    32'(err_a),    32'(e));
         chk($sformatf("%s.sticky", tag), 32'(sticky_a), 32'(st));
         chk($sformatf("%s.tick", tag),   32'(tick_a),   32'(tk));
         chk($sformatf("%s.rev", tag),    32'(rev_a),    32'(rc));
      end else begin
         chk($sformatf("%s.b.phase", tag),  32'(phase_b),  32'(ph));
         chk($sformatf("%s.b.idx", tag),    32'(idx_b),    32'(pidx));
         chk($sformatf("%s.b.valid", tag),  32'(valid_b),  32'(v));
         chk($sformatf("%s.b.locked", tag), 32'(locked_b), 32'(lk));
         chk($sformatf("%s.b.err", tag),    32'(err_b),    32'(e));
         chk($sformatf("%s.b.sticky", tag), 32'(sticky_b), 32'(st));
         chk($sformatf("%s.b.tick", tag),   32'(tick_b),   32'(tk));
         chk($sformatf("%s.b.rev", tag),    32'(rev_b),    32'(rc));
      end
   endtask

   task automatic step(input logic [4:0] c, input logic rs, input logic ce);
      code_in = c;
      resync  = rs;
      clr_err = ce;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; code_in = 5'd0; resync = 1'b0; clr_err = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      expect_all("rst", 0, 15, 0, 0, 0, 0, 0, 0);
      expect_all("rst", 1, 15, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Free run: lock after the 4th sample, ticks at samples 10 and 20.
      for (int i = 0; i < 25; i++) begin
         step(jc(i % 10), 0, 0);
         expect_all($sformatf("free%0d", i), 0, i % 10, 1, i >= 3, 0, 0,
                    (i == 10 || i == 20), (i >= 20) ? 2 : ((i >= 10) ? 1 : 0));
      end

      // Illegal code while locked at phase 4.
      step(5'b10100, 0, 0);
      expect_all("illegal", 0, 15, 0, 0, 1, 1, 0, 2);
      // The first legal code after an illegal one is not a successor.
      step(jc(5), 0, 0); expect_all("rl5", 0, 5, 1, 0, 0, 1, 0, 2);
      step(jc(6), 0, 0); expect_all("rl6", 0, 6, 1, 0, 0, 1, 0, 2);
      step(jc(7), 0, 0); expect_all("rl7", 0, 7, 1, 0, 0, 1, 0, 2);
      step(jc(8), 0, 0); expect_all("rl8", 0, 8, 1, 1, 0, 1, 0, 2);
      step(jc(9), 0, 0); expect_all("rl9", 0, 9, 1, 1, 0, 1, 0, 2);
      step(jc(0), 0, 0); expect_all("rl0", 0, 0, 1, 1, 0, 1, 1, 3);
      step(jc(1), 0, 1); expect_all("clr1", 0, 1, 1, 1, 0, 0, 0, 3);
      step(jc(2), 0, 0); expect_all("sk2", 0, 2, 1, 1, 0, 0, 0, 3);
      step(jc(3), 0, 0); expect_all("sk3", 0, 3, 1, 1, 0, 0, 0, 3);
      // Skip 3 -> 5 while clr_err is high: the set wins.
      step(jc(5), 0, 1); expect_all("skip", 0, 5, 1, 0, 1, 1, 0, 3);
      step(jc(6), 0, 1); expect_all("clr2", 0, 6, 1, 0, 0, 0, 0, 3);
      step(jc(7), 0, 0); expect_all("s7", 0, 7, 1, 0, 0, 0, 0, 3);
      step(jc(8), 0, 0); expect_all("s8", 0, 8, 1, 1, 0, 0, 0, 3);
      step(jc(9), 0, 0); expect_all("s9", 0, 9, 1, 1, 0, 0, 0, 3);
      step(jc(0), 0, 0); expect_all("s0", 0, 0, 1, 1, 0, 0, 1, 4);
      for (int p = 1; p <= 6; p++) begin
         step(jc(p), 0, 0);
         expect_all($sformatf("pre_rs%0d", p), 0, p, 1, 1, 0, 0, 0, 4);
      end
      // Reload while locked at phase 6.
      step(jc(1), 1, 0); expect_all("resync", 0, 1, 1, 0, 0, 0, 0, 4);
      step(jc(2), 0, 0); expect_all("rs2", 0, 2, 1, 0, 0, 0, 0, 4);
      step(jc(3), 0, 0); expect_all("rs3", 0, 3, 1, 0, 0, 0, 0, 4);
      step(jc(4), 0, 0); expect_all("rs4", 0, 4, 1, 1, 0, 0, 0, 4);
      // A repeated code is a fault while locked.
      step(jc(4), 0, 0); expect_all("repeat", 0, 4, 1, 0, 1, 1, 0, 4);
      // Faults while unlocked raise nothing.
      step(jc(5), 1, 0); expect_all("ul_rs", 0, 5, 1, 0, 0, 1, 0, 4);
      step(5'b01010, 0, 0); expect_all("ul_ill", 0, 15, 0, 0, 0, 1, 0, 4);
      step(jc(0), 0, 1); expect_all("clr3", 0, 0, 1, 0, 0, 0, 0, 4);

      // Wrap run with REV_W = 2 on dut_b, starting from a fresh reset.
      reset = 1'b1;
      step(jc(0), 0, 0);
      expect_all("rst2", 0, 15, 0, 0, 0, 0, 0, 0);
      expect_all("rst2", 1, 15, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 56; i++) begin
         step(jc(i % 10), 0, 0);
         expect_all($sformatf("wrap%0d", i), 1, i % 10, 1, i >= 3, 0, 0,
                    (i >= 10 && i % 10 == 0), (i / 10) % 4);
         chk($sformatf("wrap%0d.a.rev", i), 32'(rev_a), 32'(i / 10));
      end

      // Reset in the middle of a revolution.
      reset = 1'b1;
      step(jc(6), 0, 0);
      expect_all("rst3", 0, 15, 0, 0, 0, 0, 0, 0);
      expect_all("rst3", 1, 15, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step(jc(6), 0, 0); expect_all("pr6", 0, 6, 1, 0, 0, 0, 0, 0);
      step(jc(7), 0, 0); expect_all("pr7", 0, 7, 1, 0, 0, 0, 0, 0);
      step(jc(8), 0, 0); expect_all("pr8", 0, 8, 1, 0, 0, 0, 0, 0);
      step(jc(9), 0, 0); expect_all("pr9", 0, 9, 1, 1, 0, 0, 0, 0);
      step(jc(0), 0, 0); expect_all("pr0", 0, 0, 1, 1, 0, 0, 1, 1);
      expect_all("pr0", 1, 0, 1, 1, 0, 0, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
